alu_sequencer: RTL

- Micro-sequencer that drives the team's 4-bit registered ALU: issues operands and opcodes, captures the result and CF/ZF/SF flags, and writes results back to a 4x4-bit register file.
- Runs a 16-entry program loaded over a write port, supports flag-conditional branches, and reports busy/done to the host.
- Initiator side of the ALU A/B/opcode/C/flags interface.

---
 rtl/alu_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - micro-sequencer driving the registered 4-bit ALU from a 16-word program
// Optional step-limit abort enabled by defining SEQ_STEP_LIMIT_EN.
module alu_sequencer #(
    parameter int PROG_DEPTH = 16,
    parameter int PC_W       = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            prog_we,
    input  logic [PC_W-1:0] prog_addr,
    input  logic [11:0]     prog_wdata,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [3:0]      alu_a,
    output logic [3:0]      alu_b,
    output logic [2:0]      alu_op,
    input  logic [3:0]      alu_c,
    input  logic            alu_cf,
    input  logic            alu_zf,
    input  logic            alu_sf,
    input  logic [1:0]      dbg_sel,
    output logic [3:0]      dbg_data,
    output logic [2:0]      flags,
    output logic            err
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_WB, S_EXEC, S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [11:0]     mem [PROG_DEPTH];
    logic [11:0]     instr;
    logic [11:0]     fetch_word;
    logic            fetch_alu;
    logic [PC_W-1:0] pc;
    logic [3:0]      regs [4];
    logic            taken;
    logic            limit_hit;

    assign fetch_word = mem[pc];
    assign fetch_alu  = (fetch_word[11:9] >= 3'd1) && (fetch_word[11:9] <= 3'd4);
    assign dbg_data   = regs[dbg_sel];
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

    // Branch conditions look at the latched flags, i.e. the last ALU result.
    always_comb begin
        taken = 1'b0;
        case (instr[8:7])
            2'd0: taken = 1'b1;
            2'd1: taken = flags[1];
            2'd2: taken = flags[2];
            2'd3: taken = !flags[1];
            default: taken = 1'b0;
        endcase
    end

`ifdef SEQ_STEP_LIMIT_EN
    logic [7:0] step_cnt;

    // Count of completed instructions; the 255th completion aborts the run.
    assign limit_hit = (step_cnt == 8'd254);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_cnt <= 8'd0;
            err      <= 1'b0;
        end else if (state == S_IDLE && start) begin
            step_cnt <= 8'd0;
            err      <= 1'b0;
        end else if (state == S_WB || state == S_EXEC) begin
            step_cnt <= step_cnt + 8'd1;
            if (limit_hit) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign limit_hit = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_FETCH;
            S_FETCH: begin
                if (fetch_word[11:9] == 3'd0) begin
                    state_nxt = S_DONE;
                end else if (fetch_alu) begin
                    state_nxt = S_ISSUE;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_ISSUE: state_nxt = S_WB;
            S_WB:    state_nxt = limit_hit ? S_DONE : S_FETCH;
            S_EXEC:  state_nxt = limit_hit ? S_DONE : S_FETCH;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && prog_we) begin
            mem[prog_addr] <= prog_wdata;
        end
    end

    // Operands are loaded on the FETCH->ISSUE edge so they are valid throughout ISSUE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc     <= '0;
            instr  <= 12'd0;
            flags  <= 3'b010;
            alu_a  <= 4'd0;
            alu_b  <= 4'd0;
            alu_op <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= 4'd0;
            end
        end else begin
            alu_op <= 3'd0;
            case (state)
                S_IDLE: begin
                    if (start) pc <= '0;
                end
                S_FETCH: begin
                    instr <= fetch_word;
                    if (fetch_alu) begin
                        alu_a  <= regs[fetch_word[6:5]];
                        alu_b  <= regs[fetch_word[4:3]];
                        alu_op <= fetch_word[11:9];
                    end
                end
                S_WB: begin
                    regs[instr[8:7]] <= alu_c;
                    flags            <= {alu_cf, alu_zf, alu_sf};
                    pc               <= pc + 1'b1;
                end
                S_EXEC: begin
                    if (instr[11:9] == 3'd5) begin
                        regs[instr[8:7]] <= instr[3:0];
                    end
                    if (instr[11:9] == 3'd6 && taken) begin
                        pc <= instr[PC_W-1:0];
                    end else begin
                        pc <= pc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
